// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external ALU between two valid/ready requesters
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic               busy_q, busy_d;

    logic grant_any;
    logic grant_sel;
    logic rsp_take;

    // With both ports requesting, the one not served last wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && !rst && grant_any && !grant_sel;
    assign req1_ready = (state_q == IDLE) && !rst && grant_any && grant_sel;
    assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        zero_d       = zero_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d          = grant_sel ? req1_a    : req0_a;
                    b_d          = grant_sel ? req1_b    : req0_b;
                    ctrl_d       = grant_sel ? req1_ctrl : req0_ctrl;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    busy_d       = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d     = alu_result;
                zero_d       = alu_zero;
                rsp0_valid_d = ~owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_take) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    // ALU sees only registered operands, so its inputs never glitch.
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed bench for alu_share_arbiter with a behavioural model
module tb_alu_share_arbiter;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam logic [CW-1:0] ALU_AND = 4'h0;
    localparam logic [CW-1:0] ALU_OR  = 4'h1;
    localparam logic [CW-1:0] ALU_ADD = 4'h2;
    localparam logic [CW-1:0] ALU_SUB = 4'h6;
    localparam logic [CW-1:0] ALU_SLT = 4'h7;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [CW-1:0] ctrl;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [CW-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          alu_zero, busy;

    logic          p_valid[2];
    logic          p_rready[2];
    logic [W-1:0]  p_a[2];
    logic [W-1:0]  p_b[2];
    logic [CW-1:0] p_ctrl[2];

    assign req0_valid = p_valid[0];
    assign req0_a     = p_a[0];
    assign req0_b     = p_b[0];
    assign req0_ctrl  = p_ctrl[0];
    assign rsp0_ready = p_rready[0];
    assign req1_valid = p_valid[1];
    assign req1_a     = p_a[1];
    assign req1_b     = p_b[1];
    assign req1_ctrl  = p_ctrl[1];
    assign rsp1_ready = p_rready[1];

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [CW-1:0] c);
        logic [W-1:0] r;
        case (c)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return {1'b0, 32'hDEADBEEF};
        endcase
        return {(r == '0), r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    req_t         rq[2][$];
    bit           p_pend[2];
    bit           rand_mode;
    bit           m_busy;
    int           m_age, m_owner, m_last, cyc, hold_cnt;
    logic [W-1:0] m_res, m_a, m_b;
    logic [CW-1:0] m_ctrl;
    logic         m_zero;
    int           g_port[$], g_cyc[$], r_port[$], r_cyc[$], r_hold[$];
    logic [W-1:0] r_res[$];
    logic         r_zero[$];

    task automatic clear_logs();
        g_port.delete(); g_cyc.delete(); r_port.delete(); r_cyc.delete();
        r_hold.delete(); r_res.delete(); r_zero.delete();
    endtask

    task automatic drive();
        req_t r;
        for (int n = 0; n < 2; n++) begin
            if (!p_pend[n]) begin
                if (rq[n].size() > 0) begin
                    r = rq[n].pop_front();
                    p_a[n] = r.a; p_b[n] = r.b; p_ctrl[n] = r.ctrl; p_pend[n] = 1'b1;
                end else if (rand_mode && $urandom_range(0, 1) == 1) begin
                    p_a[n]    = $urandom;
                    p_b[n]    = ($urandom_range(0, 3) == 0) ? p_a[n] : $urandom;
                    p_ctrl[n] = CW'($urandom_range(0, 15));
                    p_pend[n] = 1'b1;
                end
            end
            p_valid[n] = p_pend[n];
            if (rand_mode) p_rready[n] = ($urandom_range(0, 2) != 0);
        end
    endtask

    // Model: an op handshaken in cycle T occupies the ALU in T+1 and answers from T+2 on.
    task automatic check_model();
        int g;
        if (!m_busy) begin
            g = -1;
            if (p_valid[0] && p_valid[1]) g = 1 - m_last;
            else if (p_valid[0]) g = 0;
            else if (p_valid[1]) g = 1;
            check("req0_ready", req0_ready, g == 0);
            check("req1_ready", req1_ready, g == 1);
            check("busy_idle", busy, 0);
            check("rsp_valid_idle", {rsp1_valid, rsp0_valid}, 0);
            if (g >= 0) begin
                m_busy = 1; m_age = 0; m_owner = g; m_last = g; hold_cnt = 0;
                m_a = p_a[g]; m_b = p_b[g]; m_ctrl = p_ctrl[g];
                {m_zero, m_res} = alu_ref(p_a[g], p_b[g], p_ctrl[g]);
                p_pend[g] = 1'b0;
                g_port.push_back(g); g_cyc.push_back(cyc);
            end
        end else begin
            m_age++;
            check("busy_op", busy, 1);
            check("req_ready_busy", {req1_ready, req0_ready}, 0);
            if (m_age == 1) begin
                check("rsp_valid_exec", {rsp1_valid, rsp0_valid}, 0);
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                check("alu_ctrl", alu_ctrl, m_ctrl);
            end else begin
                check("rsp_valid", {rsp1_valid, rsp0_valid}, (m_owner == 1) ? 2'b10 : 2'b01);
                check("rsp_result", (m_owner == 1) ? rsp1_result : rsp0_result, m_res);
                check("rsp_zero", (m_owner == 1) ? rsp1_zero : rsp0_zero, m_zero);
                hold_cnt++;
                if (p_rready[m_owner]) begin
                    m_busy = 0;
                    r_port.push_back(m_owner); r_res.push_back(m_res); r_zero.push_back(m_zero);
                    r_cyc.push_back(cyc); r_hold.push_back(hold_cnt);
                end
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        check_model();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int limit, input bit bp);
        int k = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || p_pend[0] || p_pend[1] || m_busy) && k < limit) begin
            if (bp) p_rready[0] = (hold_cnt >= 5);
            cycle();
            k++;
        end
        if (k >= limit) check("timeout", 0, 1);
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = 1; hold_cnt = 0;
        for (int n = 0; n < 2; n++) begin
            p_pend[n] = 0; p_valid[n] = 0; rq[n].delete();
        end
    endtask

    initial begin
        cyc = 0; rand_mode = 0; m_age = 0; m_owner = 0;
        m_a = '0; m_b = '0; m_ctrl = '0; m_res = '0; m_zero = 1'b0;
        for (int n = 0; n < 2; n++) begin
            p_a[n] = '0; p_b[n] = '0; p_ctrl[n] = '0; p_rready[n] = 1'b0;
        end
        model_reset();
        rst = 1'b1;
        p_valid[0] = 1'b1; p_valid[1] = 1'b1;
        #2;
        check("rst_req_ready", {req1_ready, req0_ready}, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_busy", busy, 0);
        check("rst_regs", {alu_a, alu_b}, 0);
        check("rst_result", {rsp0_result, rsp0_zero, alu_ctrl}, 0);
        p_valid[0] = 1'b0; p_valid[1] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        p_rready[0] = 1'b1; p_rready[1] = 1'b1;

        clear_logs();
        rq[0].push_back('{32'd5, 32'd7, ALU_ADD});
        run_until_idle(20, 0);
        check("single_cnt", r_port.size(), 1);
        if (r_port.size() == 1 && g_cyc.size() == 1) begin
            check("single_port", r_port[0], 0);
            check("single_result", r_res[0], 12);
            check("single_zero", r_zero[0], 0);
            check("single_latency", r_cyc[0] - g_cyc[0], 2);
        end

        clear_logs();
        rq[1].push_back('{32'd9, 32'd9, ALU_SUB});
        run_until_idle(20, 0);
        check("zero_cnt", r_port.size(), 1);
        if (r_port.size() == 1 && g_cyc.size() == 1) begin
            check("zero_port", r_port[0], 1);
            check("zero_result", r_res[0], 0);
            check("zero_flag", r_zero[0], 1);
            check("zero_latency", r_cyc[0] - g_cyc[0], 2);
        end

        clear_logs();
        for (int i = 1; i <= 4; i++) begin
            rq[0].push_back('{32'(i), 32'd1, ALU_ADD});
            rq[1].push_back('{32'(100 + i), 32'd1, ALU_ADD});
        end
        run_until_idle(60, 0);
        check("rr_cnt", r_port.size(), 8);
        if (r_port.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("rr_port", r_port[k], k % 2);
                check("rr_result", r_res[k], (k % 2 == 0) ? (k / 2 + 2) : (100 + k / 2 + 2));
            end
        end

        clear_logs();
        p_rready[0] = 1'b0;
        rq[0].push_back('{32'hFFFFFFFF, 32'd1, ALU_SLT});
        rq[1].push_back('{32'd3, 32'd4, ALU_ADD});
        run_until_idle(60, 1);
        p_rready[0] = 1'b1;
        check("bp_cnt", r_port.size(), 2);
        if (r_port.size() == 2 && g_port.size() == 2) begin
            check("bp_port", r_port[0], 0);
            check("bp_result", r_res[0], 1);
            check("bp_hold", r_hold[0], 6);
            check("bp_next_port", g_port[1], 1);
            check("bp_next_grant", g_cyc[1] - r_cyc[0], 1);
            check("bp_port1_result", r_res[1], 7);
        end

        clear_logs();
        rq[0].push_back('{32'h12345678, 32'd9, 4'hF});
        run_until_idle(20, 0);
        check("bad_ctrl_cnt", r_port.size(), 1);
        if (r_port.size() == 1) begin
            check("bad_ctrl_result", r_res[0], 32'hDEADBEEF);
            check("bad_ctrl_zero", r_zero[0], 0);
        end

        rq[0].push_back('{32'd1, 32'd2, ALU_ADD});
        for (int k = 0; k < 10 && !m_busy; k++) cycle();
        check("rst_mid_started", m_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_mid_regs", {alu_a, alu_b, alu_ctrl}, 0);
        check("rst_mid_result", {rsp0_result, rsp0_zero}, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        rq[0].push_back('{32'd10, 32'd20, ALU_OR});
        rq[1].push_back('{32'd30, 32'd40, ALU_AND});
        run_until_idle(30, 0);
        check("rst_tie_cnt", g_port.size(), 2);
        if (g_port.size() == 2) check("rst_tie_first", g_port[0], 0);

        rand_mode = 1;
        repeat (400) cycle();
        rand_mode = 0;
        p_rready[0] = 1'b1; p_rready[1] = 1'b1;
        run_until_idle(50, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
